// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO target: oversamples MDC in clk_int, decodes frames, serves a 32x16 register file.
// Optional MDIO_PREAMBLE_SUPPRESS_EN: after one complete frame, ST is accepted with any preamble.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h0141,
  parameter logic [15:0] PHY_ID2  = 16'h0DD1,
  parameter logic [15:0] BMCR_RST = 16'h1140
) (
  input  logic        clk_int,
  input  logic        rst_int_n,
  input  logic        phy_mdc,
  input  logic        phy_mdio_i,
  output logic        phy_mdio_o,
  output logic        phy_mdio_oen,
  output logic        bmcr_loopback,
  output logic        bmcr_soft_rst,
  output logic        reg_wr_stb,
  output logic [4:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data
);

  typedef enum logic [2:0] {
    StIdle,
    StSt2,
    StOp,
    StAddr,
    StTa,
    StData
  } state_e;

  localparam logic [5:0] PreambleLen = 6'd32;

  // Input synchronizers
  logic mdc_s1_q, mdc_s2_q, mdc_s3_q;
  logic mdio_s1_q, mdio_s2_q;
  logic rise;
  logic mdio_bit;

  always_ff @(posedge clk_int or negedge rst_int_n) begin
    if (!rst_int_n) begin
      mdc_s1_q  <= 1'b0;
      mdc_s2_q  <= 1'b0;
      mdc_s3_q  <= 1'b0;
      mdio_s1_q <= 1'b0;
      mdio_s2_q <= 1'b0;
    end else begin
      mdc_s1_q  <= phy_mdc;
      mdc_s2_q  <= mdc_s1_q;
      mdc_s3_q  <= mdc_s2_q;
      mdio_s1_q <= phy_mdio_i;
      mdio_s2_q <= mdio_s1_q;
    end
  end

  assign rise     = mdc_s2_q & ~mdc_s3_q;
  assign mdio_bit = mdio_s2_q;

  // Frame decoder state
  state_e      state_q, state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  op_q, op_d;
  logic [8:0]  addr_q, addr_d;
  logic [4:0]  regad_q, regad_d;
  logic        match_q, match_d;
  logic        ta_ok_q, ta_ok_d;
  logic [15:0] rd_sr_q, rd_sr_d;
  logic [15:0] wr_sr_q, wr_sr_d;
  logic        mdio_o_q, mdio_o_d;
  logic        mdio_oen_q, mdio_oen_d;
  logic        wr_stb_q;
  logic [4:0]  wr_addr_q;
  logic [15:0] wr_data_q;
  logic        soft_rst_q, soft_rst_d;
  logic        commit;
  logic [15:0] commit_data;
  logic        serve_rd;
  logic        st_ok;
  logic [4:0]  rd_regad;
  logic [15:0] rd_value;

  logic [15:0] regs_q [32];

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  logic frame_seen_q;

  always_ff @(posedge clk_int or negedge rst_int_n) begin
    if (!rst_int_n) begin
      frame_seen_q <= 1'b0;
    end else if (rise && state_q == StData && bit_cnt_q == 4'd15) begin
      frame_seen_q <= 1'b1;
    end
  end

  assign st_ok = (pre_cnt_q == PreambleLen) || frame_seen_q;
`else
  assign st_ok = (pre_cnt_q == PreambleLen);
`endif

  assign serve_rd    = (op_q == 2'b10) && match_q;
  assign commit_data = {wr_sr_q[14:0], mdio_bit};
  assign rd_regad    = {addr_q[3:0], mdio_bit};

  always_comb begin
    rd_value = regs_q[rd_regad];
    if (rd_regad == 5'd2) begin
      rd_value = PHY_ID1;
    end else if (rd_regad == 5'd3) begin
      rd_value = PHY_ID2;
    end
  end

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    regad_d    = regad_q;
    match_d    = match_q;
    ta_ok_d    = ta_ok_q;
    rd_sr_d    = rd_sr_q;
    wr_sr_d    = wr_sr_q;
    mdio_o_d   = mdio_o_q;
    mdio_oen_d = mdio_oen_q;
    soft_rst_d = 1'b0;
    commit     = 1'b0;

    if (rise) begin
      unique case (state_q)
        StIdle: begin
          if (mdio_bit) begin
            if (pre_cnt_q != PreambleLen) pre_cnt_d = pre_cnt_q + 6'd1;
          end else begin
            pre_cnt_d = 6'd0;
            if (st_ok) state_d = StSt2;
          end
        end
        StSt2: begin
          bit_cnt_d = 4'd0;
          state_d   = mdio_bit ? StOp : StIdle;
        end
        StOp: begin
          op_d = {op_q[0], mdio_bit};
          if (bit_cnt_q == 4'd0) begin
            bit_cnt_d = 4'd1;
          end else begin
            bit_cnt_d = 4'd0;
            state_d   = (op_q[0] != mdio_bit) ? StAddr : StIdle;
          end
        end
        StAddr: begin
          addr_d = {addr_q[7:0], mdio_bit};
          if (bit_cnt_q == 4'd9) begin
            bit_cnt_d = 4'd0;
            match_d   = (addr_q[8:4] == PHY_ADDR);
            regad_d   = rd_regad;
            rd_sr_d   = rd_value;
            state_d   = StTa;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        StTa: begin
          if (bit_cnt_q == 4'd0) begin
            bit_cnt_d = 4'd1;
            ta_ok_d   = mdio_bit;
            if (serve_rd) begin
              mdio_oen_d = 1'b1;
              mdio_o_d   = 1'b0;
            end
          end else begin
            bit_cnt_d = 4'd0;
            ta_ok_d   = ta_ok_q & ~mdio_bit;
            state_d   = StData;
            if (serve_rd) begin
              mdio_o_d = rd_sr_q[15];
              rd_sr_d  = {rd_sr_q[14:0], 1'b0};
            end
          end
        end
        StData: begin
          wr_sr_d = commit_data;
          if (bit_cnt_q == 4'd15) begin
            bit_cnt_d  = 4'd0;
            pre_cnt_d  = 6'd0;
            state_d    = StIdle;
            mdio_oen_d = 1'b0;
            mdio_o_d   = 1'b0;
            if (op_q == 2'b01 && match_q && ta_ok_q) begin
              commit     = 1'b1;
              soft_rst_d = (regad_q == 5'd0) && commit_data[15];
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (serve_rd) begin
              mdio_o_d = rd_sr_q[15];
              rd_sr_d  = {rd_sr_q[14:0], 1'b0};
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_int or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= StIdle;
      pre_cnt_q  <= 6'd0;
      bit_cnt_q  <= 4'd0;
      op_q       <= 2'b00;
      addr_q     <= 9'd0;
      regad_q    <= 5'd0;
      match_q    <= 1'b0;
      ta_ok_q    <= 1'b0;
      rd_sr_q    <= 16'd0;
      wr_sr_q    <= 16'd0;
      mdio_o_q   <= 1'b0;
      mdio_oen_q <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= 5'd0;
      wr_data_q  <= 16'd0;
      soft_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      regad_q    <= regad_d;
      match_q    <= match_d;
      ta_ok_q    <= ta_ok_d;
      rd_sr_q    <= rd_sr_d;
      wr_sr_q    <= wr_sr_d;
      mdio_o_q   <= mdio_o_d;
      mdio_oen_q <= mdio_oen_d;
      wr_stb_q   <= commit;
      soft_rst_q <= soft_rst_d;
      if (commit) begin
        wr_addr_q <= regad_q;
        wr_data_q <= commit_data;
      end
    end
  end

  // Registers 2/3 are served from parameters, so their storage is never written.
  always_ff @(posedge clk_int or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == 0) ? BMCR_RST : 16'd0;
      end
    end else if (commit) begin
      if (soft_rst_d) begin
        for (int i = 0; i < 32; i++) begin
          regs_q[i] <= (i == 0) ? (BMCR_RST & 16'h7FFF) : 16'd0;
        end
      end else if (regad_q != 5'd2 && regad_q != 5'd3) begin
        regs_q[regad_q] <= commit_data;
      end
    end
  end

  assign phy_mdio_o    = mdio_o_q;
  assign phy_mdio_oen  = mdio_oen_q;
  assign bmcr_loopback = regs_q[0][14];
  assign bmcr_soft_rst = soft_rst_q;
  assign reg_wr_stb    = wr_stb_q;
  assign reg_wr_addr   = wr_addr_q;
  assign reg_wr_data   = wr_data_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: bit-bangs MDIO frames and checks line, strobes and regs.
module tb_mdio_phy_responder;

  localparam int Half = 8;

  logic        clk;
  logic        rst_n;
  logic        mdc;
  logic        m_oen;
  logic        m_val;
  logic        line;
  logic        dut_o;
  logic        dut_oen;
  logic        loopback;
  logic        soft_rst;
  logic        wr_stb;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  int checks;
  int failures;
  int stb_cnt;
  int soft_cnt;
  int soft_alone;
  logic [4:0]  last_addr;
  logic [15:0] last_data;

  assign line = dut_oen ? dut_o : (m_oen ? m_val : 1'b1);

  mdio_phy_responder dut (
    .clk_int      (clk),
    .rst_int_n    (rst_n),
    .phy_mdc      (mdc),
    .phy_mdio_i   (line),
    .phy_mdio_o   (dut_o),
    .phy_mdio_oen (dut_oen),
    .bmcr_loopback(loopback),
    .bmcr_soft_rst(soft_rst),
    .reg_wr_stb   (wr_stb),
    .reg_wr_addr  (wr_addr),
    .reg_wr_data  (wr_data)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb) begin
      stb_cnt   <= stb_cnt + 1;
      last_addr <= wr_addr;
      last_data <= wr_data;
    end
    if (soft_rst) soft_cnt <= soft_cnt + 1;
    if (soft_rst && !wr_stb) soft_alone <= soft_alone + 1;
  end

  // Sends one frame; stop_at >= 0 aborts after that bit index (MDC left low).
  task automatic run_frame(input int pre, input logic [1:0] op, input logic [4:0] phyad,
                           input logic [4:0] regad, input logic [1:0] ta,
                           input logic [15:0] wdata, input int stop_at,
                           output logic [15:0] rdata, output logic ta2, output int oen_cnt);
    logic [31:0] f;
    logic        is_rd;
    logic        smp;
    int          pos;
    f       = {2'b01, op, phyad, regad, ta, wdata};
    is_rd   = (op == 2'b10);
    rdata   = 16'h0000;
    ta2     = 1'b1;
    oen_cnt = 0;
    for (int k = 0; k < pre + 32; k++) begin
      pos = k - pre;
      if (pos < 0) begin
        m_oen = 1'b1;
        m_val = 1'b1;
      end else begin
        m_oen = !(is_rd && pos >= 14);
        m_val = f[31-pos];
      end
      repeat (Half) @(posedge clk);
      #1;
      smp = line;
      if (dut_oen) oen_cnt++;
      if (pos == 15) ta2 = smp;
      if (pos >= 16) rdata[31-pos] = smp;
      mdc = 1'b1;
      repeat (Half) @(posedge clk);
      #1;
      mdc = 1'b0;
      if (stop_at >= 0 && k == stop_at) return;
    end
    m_oen = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_oen !== 1'b0) begin failures++; $display("FAIL reset_oen got=%b want=0", dut_oen); end
    checks++;
    if (dut_o !== 1'b0) begin failures++; $display("FAIL reset_o got=%b want=0", dut_o); end
    checks++;
    if (wr_stb !== 1'b0) begin failures++; $display("FAIL reset_stb got=%b want=0", wr_stb); end
    checks++;
    if (soft_rst !== 1'b0) begin failures++; $display("FAIL reset_soft got=%b want=0", soft_rst); end
    checks++;
    if (loopback !== 1'b0) begin failures++; $display("FAIL reset_loopback got=%b want=0", loopback); end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_short_preamble();
    logic [15:0] rd;
    logic        t2;
    int          oc;
    run_frame(31, 2'b10, 5'd1, 5'd2, 2'b11, 16'h0, -1, rd, t2, oc);
    checks++;
    if (oc !== 0) begin failures++; $display("FAIL short_pre_oen got=%0d want=0", oc); end
  endtask

  task automatic test_read_id();
    logic [15:0] rd;
    logic        t2;
    int          oc;
    run_frame(32, 2'b10, 5'd1, 5'd2, 2'b11, 16'h0, -1, rd, t2, oc);
    checks++;
    if (rd !== 16'h0141) begin failures++; $display("FAIL read_id1 got=%h want=0141", rd); end
    checks++;
    if (t2 !== 1'b0) begin failures++; $display("FAIL read_ta2 got=%b want=0", t2); end
    checks++;
    if (oc !== 17) begin failures++; $display("FAIL read_oen_cnt got=%0d want=17", oc); end
    checks++;
    if (dut_oen !== 1'b0) begin failures++; $display("FAIL read_oen_after got=%b want=0", dut_oen); end
    run_frame(32, 2'b10, 5'd1, 5'd1, 2'b11, 16'h0, -1, rd, t2, oc);
    checks++;
    if (rd !== 16'h0000) begin failures++; $display("FAIL read_reg1 got=%h want=0000", rd); end
  endtask

  task automatic test_write_read();
    logic [15:0] rd;
    logic        t2;
    int          oc;
    int          s0;
    s0 = stb_cnt;
    run_frame(32, 2'b01, 5'd1, 5'd4, 2'b10, 16'hA5A5, -1, rd, t2, oc);
    checks++;
    if (stb_cnt - s0 !== 1) begin failures++; $display("FAIL wr_stb_cnt got=%0d want=1", stb_cnt - s0); end
    checks++;
    if (last_addr !== 5'd4) begin failures++; $display("FAIL wr_addr got=%0d want=4", last_addr); end
    checks++;
    if (last_data !== 16'hA5A5) begin failures++; $display("FAIL wr_data got=%h want=a5a5", last_data); end
    run_frame(32, 2'b10, 5'd1, 5'd4, 2'b11, 16'h0, -1, rd, t2, oc);
    checks++;
    if (rd !== 16'hA5A5) begin failures++; $display("FAIL rd_reg4 got=%h want=a5a5", rd); end
  endtask

  task automatic test_write_id();
    logic [15:0] rd;
    logic        t2;
    int          oc;
    int          s0;
    s0 = stb_cnt;
    run_frame(32, 2'b01, 5'd1, 5'd2, 2'b10, 16'hFFFF, -1, rd, t2, oc);
    checks++;
    if (stb_cnt - s0 !== 1) begin failures++; $display("FAIL wr_id_stb got=%0d want=1", stb_cnt - s0); end
    run_frame(32, 2'b10, 5'd1, 5'd2, 2'b11, 16'h0, -1, rd, t2, oc);
    checks++;
    if (rd !== 16'h0141) begin failures++; $display("FAIL wr_id_readback got=%h want=0141", rd); end
  endtask

  task automatic test_bmcr();
    logic [15:0] rd;
    logic        t2;
    int          oc;
    int          sc0;
    run_frame(32, 2'b01, 5'd1, 5'd0, 2'b10, 16'h4000, -1, rd, t2, oc);
    checks++;
    if (loopback !== 1'b1) begin failures++; $display("FAIL loopback_set got=%b want=1", loopback); end
    run_frame(32, 2'b10, 5'd1, 5'd0, 2'b11, 16'h0, -1, rd, t2, oc);
    checks++;
    if (rd !== 16'h4000) begin failures++; $display("FAIL bmcr_read got=%h want=4000", rd); end
    sc0 = soft_cnt;
    run_frame(32, 2'b01, 5'd1, 5'd0, 2'b10, 16'h8000, -1, rd, t2, oc);
    checks++;
    if (soft_cnt - sc0 !== 1) begin failures++; $display("FAIL soft_rst_cnt got=%0d want=1", soft_cnt - sc0); end
    checks++;
    if (soft_alone !== 0) begin failures++; $display("FAIL soft_rst_align got=%0d want=0", soft_alone); end
    checks++;
    if (loopback !== 1'b0) begin failures++; $display("FAIL loopback_clr got=%b want=0", loopback); end
    run_frame(32, 2'b10, 5'd1, 5'd0, 2'b11, 16'h0, -1, rd, t2, oc);
    checks++;
    if (rd !== 16'h1140) begin failures++; $display("FAIL bmcr_after_rst got=%h want=1140", rd); end
    run_frame(32, 2'b10, 5'd1, 5'd4, 2'b11, 16'h0, -1, rd, t2, oc);
    checks++;
    if (rd !== 16'h0000) begin failures++; $display("FAIL reg4_after_rst got=%h want=0000", rd); end
  endtask

  task automatic test_mismatch();
    logic [15:0] rd;
    logic        t2;
    int          oc;
    int          s0;
    run_frame(32, 2'b10, 5'd2, 5'd2, 2'b11, 16'h0, -1, rd, t2, oc);
    checks++;
    if (oc !== 0) begin failures++; $display("FAIL mismatch_oen got=%0d want=0", oc); end
    s0 = stb_cnt;
    run_frame(32, 2'b01, 5'd1, 5'd4, 2'b11, 16'h1234, -1, rd, t2, oc);
    checks++;
    if (stb_cnt - s0 !== 0) begin failures++; $display("FAIL bad_ta_stb got=%0d want=0", stb_cnt - s0); end
    run_frame(32, 2'b10, 5'd1, 5'd4, 2'b11, 16'h0, -1, rd, t2, oc);
    checks++;
    if (rd !== 16'h0000) begin failures++; $display("FAIL bad_ta_reg4 got=%h want=0000", rd); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd;
    logic        t2;
    int          oc;
    run_frame(32, 2'b10, 5'd1, 5'd3, 2'b11, 16'h0, -1, rd, t2, oc);
    checks++;
    if (rd !== 16'h0DD1) begin failures++; $display("FAIL b2b_first got=%h want=0dd1", rd); end
    run_frame(0, 2'b10, 5'd1, 5'd3, 2'b11, 16'h0, -1, rd, t2, oc);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    checks++;
    if (oc !== 17) begin failures++; $display("FAIL b2b_oen got=%0d want=17", oc); end
    checks++;
    if (rd !== 16'h0DD1) begin failures++; $display("FAIL b2b_second got=%h want=0dd1", rd); end
`else
    checks++;
    if (oc !== 0) begin failures++; $display("FAIL b2b_oen got=%0d want=0", oc); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd;
    logic        t2;
    int          oc;
    run_frame(32, 2'b10, 5'd1, 5'd2, 2'b11, 16'h0, 32 + 20, rd, t2, oc);
    checks++;
    if (dut_oen !== 1'b1) begin failures++; $display("FAIL mid_driving got=%b want=1", dut_oen); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_oen !== 1'b0) begin failures++; $display("FAIL mid_rst_oen got=%b want=0", dut_oen); end
    m_oen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    run_frame(32, 2'b10, 5'd1, 5'd3, 2'b11, 16'h0, -1, rd, t2, oc);
    checks++;
    if (rd !== 16'h0DD1) begin failures++; $display("FAIL mid_rst_reread got=%h want=0dd1", rd); end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    stb_cnt    = 0;
    soft_cnt   = 0;
    soft_alone = 0;
    last_addr  = 5'd0;
    last_data  = 16'd0;
    rst_n      = 1'b0;
    mdc        = 1'b0;
    m_oen      = 1'b0;
    m_val      = 1'b1;
    test_reset();
    test_short_preamble();
    test_read_id();
    test_write_read();
    test_write_id();
    test_bmcr();
    test_mismatch();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
